// File: rtl/bank_req_queue.sv
// Request queue between a crossbar bank output and the bank pipeline.
// Circular buffer with per-channel pending counters and a sticky one-hot error flag.
package bank_req_queue_pkg;
   typedef struct packed {
      logic [7:0] num_banks;
      logic [7:0] num_ch;
   } mpc_cfg_t;

   typedef struct packed {
      logic [2:0]  channel_1hot_id;
      logic [1:0]  op;
      logic [15:0] addr;
      logic [31:0] wdata;
   } bank_req_t;
endpackage

module bank_req_queue
   import bank_req_queue_pkg::*;
#(
   parameter mpc_cfg_t    Cfg         = '0,
   parameter type         wbufWidth_t = logic,
   parameter int unsigned DEPTH       = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                u_bank_req_valid,
   output logic                                u_bank_req_ready,
   input  bank_req_t                           u_bank_req,
   input  wbufWidth_t                          u_bank_req_wbuf_id,
   output logic                                d_pipe_req_valid,
   input  logic                                d_pipe_req_ready,
   output bank_req_t                           d_pipe_req,
   output wbufWidth_t                          d_pipe_req_wbuf_id,
   output logic [2:0][$clog2(DEPTH+1)-1:0]     ch_pending_cnt,
   output logic                                q_full,
   output logic                                q_empty,
   output logic                                err_not_1hot
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [AW:0]          wptr_q, wptr_d;
   logic [AW:0]          rptr_q, rptr_d;
   logic [2:0][CW-1:0]   cnt_q, cnt_d;
   logic                 err_q, err_d;
   bank_req_t            mem_q  [DEPTH];
   wbufWidth_t           wbuf_q [DEPTH];
   bank_req_t            head;
   logic                 push, pop;

   // Full/empty come from registered pointers only, so a same-cycle pop never frees a slot early.
   assign q_empty = (wptr_q == rptr_q);
   assign q_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign u_bank_req_ready = !q_full;
   assign d_pipe_req_valid = !q_empty;

   assign push = u_bank_req_valid && !q_full;
   assign pop  = d_pipe_req_ready && !q_empty;

   assign head               = mem_q[rptr_q[AW-1:0]];
   assign d_pipe_req         = head;
   assign d_pipe_req_wbuf_id = wbuf_q[rptr_q[AW-1:0]];
   assign ch_pending_cnt     = cnt_q;
   assign err_not_1hot       = err_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (push) begin
         wptr_d = wptr_q + (AW+1)'(1);
         if (!$onehot(u_bank_req.channel_1hot_id)) err_d = 1'b1;
      end
      if (pop) rptr_d = rptr_q + (AW+1)'(1);
      for (int unsigned i = 0; i < 3; i++) begin
         case ({push && u_bank_req.channel_1hot_id[i], pop && head.channel_1hot_id[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   // Payload storage is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]]  <= u_bank_req;
         wbuf_q[wptr_q[AW-1:0]] <= u_bank_req_wbuf_id;
      end
   end

endmodule

// File: tb/tb_bank_req_queue.sv
// Directed self-checking bench for bank_req_queue (DEPTH=4, 4-bit wbuf id).
module tb_bank_req_queue;
   import bank_req_queue_pkg::*;

   typedef logic [3:0] wbuf_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             u_valid = 1'b0;
   logic             u_ready;
   bank_req_t        u_req = '0;
   wbuf_t            u_wbuf = '0;
   logic             d_valid;
   logic             d_ready = 1'b0;
   bank_req_t        d_req;
   wbuf_t            d_wbuf;
   logic [2:0][2:0]  cnt;
   logic             full, empty, err;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   bank_req_queue #(
      .DEPTH      (4),
      .wbufWidth_t(wbuf_t)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .u_bank_req_valid  (u_valid),
      .u_bank_req_ready  (u_ready),
      .u_bank_req        (u_req),
      .u_bank_req_wbuf_id(u_wbuf),
      .d_pipe_req_valid  (d_valid),
      .d_pipe_req_ready  (d_ready),
      .d_pipe_req        (d_req),
      .d_pipe_req_wbuf_id(d_wbuf),
      .ch_pending_cnt    (cnt),
      .q_full            (full),
      .q_empty           (empty),
      .err_not_1hot      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bank_req_t mk(input logic [2:0] id, input logic [15:0] a);
      bank_req_t r;
      r.channel_1hot_id = id;
      r.op              = a[1:0];
      r.addr            = a;
      r.wdata           = {16'hC0DE, a};
      return r;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_empty"}, empty, 1);
      check({tag, "_full"}, full, 0);
      check({tag, "_dvalid"}, d_valid, 0);
      check({tag, "_uready"}, u_ready, 1);
      check({tag, "_cnt"}, cnt, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      logic [2:0]  ids [5];
      logic [15:0] exp_addr [4];
      ids[0] = 3'b001; ids[1] = 3'b010; ids[2] = 3'b010; ids[3] = 3'b100; ids[4] = 3'b001;

      // Reset state
      #2;
      check_reset_state("rst");
      step();
      rst_n = 1'b1;
      step();

      // Fill with downstream stalled: 4 accepted, 5th refused
      for (int k = 0; k < 5; k++) begin
         u_valid = 1'b1;
         u_req   = mk(ids[k], 16'(16'h10 + k));
         u_wbuf  = wbuf_t'(k + 1);
         check($sformatf("fill_rdy%0d", k), u_ready, (k < 4) ? 1 : 0);
         step();
      end
      u_valid = 1'b0;
      check("fill_full", full, 1);
      check("fill_cnt", cnt, {3'd1, 3'd2, 3'd1});
      check("fill_head", d_req.addr, 16'h10);
      step();
      check("stall_head", d_req, mk(3'b001, 16'h10));
      check("stall_wbuf", d_wbuf, 1);

      d_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain_v%0d", k), d_valid, 1);
         check($sformatf("drain_a%0d", k), d_req.addr, 16'(16'h10 + k));
         check($sformatf("drain_w%0d", k), d_wbuf, k + 1);
         if (k == 1) check("pop1_cnt", cnt, {3'd1, 3'd2, 3'd0});
         step();
      end
      check("drain_empty", empty, 1);
      check("drain_cnt", cnt, 0);

      // Streaming: one in, one out per cycle
      for (int j = 0; j < 6; j++) begin
         u_valid = 1'b1;
         u_req   = mk(3'b001 << (j % 3), 16'(16'h40 + j));
         if (j == 0) begin
            check("str_v0", d_valid, 0);
         end else begin
            check($sformatf("str_v%0d", j), d_valid, 1);
            check($sformatf("str_a%0d", j), d_req.addr, 16'(16'h40 + j - 1));
            check($sformatf("str_c%0d", j), cnt[(j - 1) % 3], 1);
         end
         step();
      end
      u_valid = 1'b0;
      check("str_last", d_req.addr, 16'h45);
      step();
      check("str_empty", empty, 1);
      check("str_cnt", cnt, 0);

      // Full + pop: push refused, then accepted next cycle
      d_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         u_valid = 1'b1;
         u_req   = mk(3'b001, 16'(16'h21 + k));
         step();
      end
      check("fp_full", full, 1);
      u_req   = mk(3'b100, 16'h28);
      d_ready = 1'b1;
      check("fp_rdy0", u_ready, 0);
      step();
      check("fp_full2", full, 0);
      check("fp_rdy1", u_ready, 1);
      check("fp_cnt", cnt, {3'd0, 3'd0, 3'd3});
      u_req   = mk(3'b010, 16'h29);
      d_ready = 1'b0;
      step();
      u_valid = 1'b0;
      check("fp_full3", full, 1);
      exp_addr[0] = 16'h22; exp_addr[1] = 16'h23; exp_addr[2] = 16'h24; exp_addr[3] = 16'h29;
      d_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fp_a%0d", k), d_req.addr, exp_addr[k]);
         step();
      end
      check("fp_empty", empty, 1);

      // Non-one-hot id
      d_ready = 1'b0;
      u_valid = 1'b1;
      u_req   = mk(3'b011, 16'h77);
      check("err_pre", err, 0);
      step();
      u_valid = 1'b0;
      check("err_set", err, 1);
      check("err_cnt", cnt, {3'd0, 3'd1, 3'd1});
      check("err_head", d_req.addr, 16'h77);
      d_ready = 1'b1;
      step();
      check("err_hold", err, 1);
      check("err_cnt2", cnt, 0);
      check("err_empty", empty, 1);

      // Asynchronous reset mid-cycle with 3 entries queued
      d_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         u_valid = 1'b1;
         u_req   = mk(3'b100, 16'(16'h50 + k));
         step();
      end
      u_valid = 1'b0;
      check("ar_pre_valid", d_valid, 1);
      check("ar_pre_cnt", cnt[2], 3);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_state("arst");
      #2;
      rst_n = 1'b1;
      step();
      check("ar_post_empty", empty, 1);
      u_valid = 1'b1;
      u_req   = mk(3'b010, 16'h99);
      step();
      u_valid = 1'b0;
      check("ar_post_valid", d_valid, 1);
      check("ar_post_head", d_req.addr, 16'h99);
      check("ar_post_cnt", cnt, {3'd0, 3'd1, 3'd0});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
